// File: rtl/soc_mem_bus.sv
// soc_mem_bus
// Data-side memory bus for the pipelined-CPU test SoC. Each CPU data access
// is decoded to the data RAM (with RAM_WAIT stall cycles), to the 256-byte
// peripheral page at MMIO_BASE, or to unmapped space (reads 0, writes dropped).
//
// Request/stall handshake: a request is present whenever cpu_we | cpu_re is
// high. While cpu_stall is 1 the CPU must hold cpu_addr/cpu_wdata/cpu_we/
// cpu_re stable. The access completes in the first cycle it is presented
// with cpu_stall = 0; load data on cpu_rdata is valid only in that cycle.
// A request with both cpu_we and cpu_re high is a store.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cpu_addr          byte address from the CPU MEM stage
//   cpu_wdata         store data
//   cpu_we, cpu_re    store / load request
//   cpu_rdata         load data (0 when no load or unmapped)
//   cpu_stall         holds the MEM stage during RAM wait states
//   ram_addr          RAM word address = cpu_addr[RAM_AW+1:2]
//   ram_we            one-cycle RAM write strobe
//   ram_wdata         RAM write data = cpu_wdata
//   ram_rdata         RAM read data (RAM clocked on ~clk)
//   gpio_out          N_OUT GPIO registers, register k at [32k+31:32k]
//   gpio_in           asynchronous input port (2-flop synchronised)
//   irq               timer interrupt level = pending & enable
//
// Peripheral page offsets: 0x00+4k gpio_out[k], 0x40 gpio_in, 0x44 cycle
// counter (any write clears), 0x48 compare, 0x4C {pending(W1C), enable}.
module soc_mem_bus #(
  parameter int          RAM_AW    = 10,
  parameter int          RAM_WAIT  = 0,
  parameter int          N_OUT     = 2,
  parameter logic [31:0] MMIO_BASE = 32'hF000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_stall,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic [32*N_OUT-1:0]   gpio_out,
  input  logic [31:0]           gpio_in,
  output logic                  irq
);

  // First byte address past the RAM; 33 bits so RAM_AW = 30 still fits.
  localparam logic [32:0] RAM_LIMIT = 33'(1) << (RAM_AW + 2);
  localparam logic [2:0]  WAIT_INIT = 3'((RAM_WAIT > 0) ? (RAM_WAIT - 1) : 0);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  // RAM access FSM (r_state is the observable FSM state)
  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        w_stall;
  logic        w_done;

  // Peripheral registers
  logic [31:0] r_gpio [N_OUT];
  logic [31:0] r_sync1;
  logic [31:0] r_sync2;
  logic [31:0] r_tick;
  logic [31:0] r_cmp;
  logic        r_en;
  logic        r_pend;

  // Decode
  logic        w_is_mmio;
  logic        w_is_ram;
  logic        w_rd;
  logic        w_ram_req;
  logic        w_mmio_wr;
  logic [7:0]  w_off;
  logic        w_match;
  logic [31:0] w_mmio_rdata;

  assign w_is_mmio = (cpu_addr[31:8] == MMIO_BASE[31:8]);
  assign w_is_ram  = !w_is_mmio && ({1'b0, cpu_addr} < RAM_LIMIT);
  assign w_rd      = cpu_re & ~cpu_we;
  assign w_ram_req = (cpu_we | cpu_re) & w_is_ram;
  assign w_mmio_wr = cpu_we & w_is_mmio;
  assign w_off     = cpu_addr[7:0];
  // Match uses the counter value before this edge.
  assign w_match   = (r_tick == r_cmp);

  // ---------------- RAM FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ram_req) begin
          if (RAM_WAIT == 0) begin
            w_done = 1'b1;
          end else begin
            w_stall     = 1'b1;
            w_cnt_nxt   = WAIT_INIT;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt != 3'd0) begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 3'd1;
        end else begin
          w_done      = w_ram_req;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign cpu_stall = w_stall;
  // A store caught by reset in its completion cycle is dropped.
  assign ram_we    = w_done & cpu_we & ~rst;
  assign ram_addr  = cpu_addr[RAM_AW+1:2];
  assign ram_wdata = cpu_wdata;

  // ---------------- Peripheral page ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_OUT; k++) r_gpio[k] <= 32'd0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (w_mmio_wr && (w_off == 8'(4 * k))) r_gpio[k] <= cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 32'd0;
      r_sync2 <= 32'd0;
      r_tick  <= 32'd0;
      r_cmp   <= 32'hFFFF_FFFF;
      r_en    <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      r_tick  <= (w_mmio_wr && (w_off == 8'h44)) ? 32'd0 : r_tick + 32'd1;
      if (w_mmio_wr && (w_off == 8'h48)) r_cmp <= cpu_wdata;
      if (w_mmio_wr && (w_off == 8'h4C)) r_en <= cpu_wdata[0];
      // A new match beats a simultaneous write-1-to-clear.
      if (w_match) r_pend <= 1'b1;
      else if (w_mmio_wr && (w_off == 8'h4C) && cpu_wdata[1]) r_pend <= 1'b0;
    end
  end

  always_comb begin
    w_mmio_rdata = 32'd0;
    for (int k = 0; k < N_OUT; k++) begin
      if (w_off == 8'(4 * k)) w_mmio_rdata = r_gpio[k];
    end
    case (w_off)
      8'h40:   w_mmio_rdata = r_sync2;
      8'h44:   w_mmio_rdata = r_tick;
      8'h48:   w_mmio_rdata = r_cmp;
      8'h4C:   w_mmio_rdata = {30'd0, r_pend, r_en};
      default: ;
    endcase
  end

  always_comb begin
    cpu_rdata = 32'd0;
    if (w_rd) begin
      if (w_is_mmio) cpu_rdata = w_mmio_rdata;
      else if (w_is_ram && w_done) cpu_rdata = ram_rdata;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_gpio_out
    assign gpio_out[32*g +: 32] = r_gpio[g];
  end

  assign irq = r_pend & r_en;

endmodule

// File: tb/tb_soc_mem_bus.sv
// Testbench for soc_mem_bus. Two instances share the CPU-side inputs:
// dut0 has RAM_WAIT=0, dut3 has RAM_WAIT=3. Each instance has its own RAM
// array (written on the falling edge, read combinationally). A behavioural
// model of the register page and RAM contents predicts dut0 responses.
module tb_soc_mem_bus;

  localparam logic [31:0] MB = 32'hF000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, gpio_in;
  logic        cpu_we, cpu_re;

  logic [31:0] rdata0, rdata3, ram_wdata0, ram_wdata3, ram_rdata0, ram_rdata3;
  logic        stall0, stall3, ram_we0, ram_we3, irq0, irq3;
  logic [9:0]  ram_addr0, ram_addr3;
  logic [63:0] gpio0, gpio3;

  logic [31:0] mem0 [1024];
  logic [31:0] mem3 [1024];

  soc_mem_bus #(.RAM_AW(10), .RAM_WAIT(0), .N_OUT(2), .MMIO_BASE(MB)) dut0 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(rdata0), .cpu_stall(stall0),
    .ram_addr(ram_addr0), .ram_we(ram_we0), .ram_wdata(ram_wdata0),
    .ram_rdata(ram_rdata0), .gpio_out(gpio0), .gpio_in(gpio_in), .irq(irq0));

  soc_mem_bus #(.RAM_AW(10), .RAM_WAIT(3), .N_OUT(2), .MMIO_BASE(MB)) dut3 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(rdata3), .cpu_stall(stall3),
    .ram_addr(ram_addr3), .ram_we(ram_we3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata3), .gpio_out(gpio3), .gpio_in(gpio_in), .irq(irq3));

  assign ram_rdata0 = mem0[ram_addr0];
  assign ram_rdata3 = mem3[ram_addr3];

  always @(negedge clk) begin
    if (ram_we0) mem0[ram_addr0] <= ram_wdata0;
    if (ram_we3) mem3[ram_addr3] <= ram_wdata3;
  end

  int n_chk = 0;
  int n_err = 0;

  // ---------------- reference model (dut0) ----------------
  logic [31:0] m_ram [1024];
  logic [31:0] m_gpio [2];
  logic [31:0] m_cnt, m_cmp, m_in_d1, m_in_d2;
  logic        m_en, m_pend;

  logic [31:0] exp_q [$];

  // Sampled DUT outputs and model predictions for the last bus_cycle
  logic [31:0] s_rdata0, s_rdata3, e_rdata;
  logic        s_stall0, s_stall3, s_ram_we0, s_ram_we3, s_irq0, e_irq;
  logic [9:0]  s_ram_addr0, s_ram_addr3;
  logic [63:0] s_gpio0, e_gpio;

  function automatic logic is_mmio(input logic [31:0] a);
    return a[31:8] == 24'hF0_0000;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic re, input logic we);
    if (!re || we) return 32'd0;
    if (is_mmio(a)) begin
      case (a[7:0])
        8'h00:   return m_gpio[0];
        8'h04:   return m_gpio[1];
        8'h40:   return m_in_d2;
        8'h44:   return m_cnt;
        8'h48:   return m_cmp;
        8'h4C:   return {30'd0, m_pend, m_en};
        default: return 32'd0;
      endcase
    end
    if (a < 32'h1000) return m_ram[a[11:2]];
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_gpio[0] = 0; m_gpio[1] = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF;
    m_en = 0; m_pend = 0; m_in_d1 = 0; m_in_d2 = 0;
  endtask

  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic mw;
    mw = we && is_mmio(a);
    if (m_cnt == m_cmp) m_pend = 1'b1;
    else if (mw && a[7:0] == 8'h4C && wd[1]) m_pend = 1'b0;
    if (mw && a[7:0] == 8'h44) m_cnt = 0;
    else m_cnt = m_cnt + 1;
    if (mw && a[7:0] == 8'h00) m_gpio[0] = wd;
    if (mw && a[7:0] == 8'h04) m_gpio[1] = wd;
    if (mw && a[7:0] == 8'h48) m_cmp = wd;
    if (mw && a[7:0] == 8'h4C) m_en = wd[0];
    if (we && !is_mmio(a) && a < 32'h1000) m_ram[a[11:2]] = wd;
    m_in_d2 = m_in_d1;
    m_in_d1 = gpio_in;
  endtask

  // One bus cycle: entered just after a rising edge, leaves just after the next.
  task automatic bus_cycle(input logic we, input logic re, input logic [31:0] a, input logic [31:0] wd);
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = wd;
    e_rdata = model_read(a, re, we);
    e_irq   = m_pend & m_en;
    e_gpio  = {m_gpio[1], m_gpio[0]};
    @(negedge clk); #1;
    s_rdata0 = rdata0; s_stall0 = stall0; s_ram_we0 = ram_we0; s_ram_addr0 = ram_addr0;
    s_gpio0 = gpio0; s_irq0 = irq0;
    s_rdata3 = rdata3; s_stall3 = stall3; s_ram_we3 = ram_we3; s_ram_addr3 = ram_addr3;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(we, a, wd);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    bus_cycle(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus_cycle(0, 0, 0, 0);
    bus_cycle(0, 0, 0, 0);
    rst = 1'b0;
    bus_cycle(0, 1, MB + 32'h44, 0);
    n_chk++; if (s_stall0 !== 1'b0) begin n_err++; $display("FAIL reset_stall0: got %b want 0", s_stall0); end
    n_chk++; if (s_stall3 !== 1'b0) begin n_err++; $display("FAIL reset_stall3: got %b want 0", s_stall3); end
    n_chk++; if (s_ram_we0 !== 1'b0 || s_ram_we3 !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %b%b want 00", s_ram_we0, s_ram_we3); end
    n_chk++; if (s_irq0 !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", s_irq0); end
    n_chk++; if (s_gpio0 !== 64'd0) begin n_err++; $display("FAIL reset_gpio: got %h want 0", s_gpio0); end
    n_chk++; if (s_rdata0 !== 32'd0) begin n_err++; $display("FAIL reset_counter: got %h want 0", s_rdata0); end
    bus_cycle(0, 1, MB + 32'h48, 0);
    n_chk++; if (s_rdata0 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_compare: got %h want ffffffff", s_rdata0); end
    bus_cycle(0, 1, MB + 32'h4C, 0);
    n_chk++; if (s_rdata0 !== 32'd0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", s_rdata0); end
  endtask

  task automatic test_ram_wait0();
    bus_cycle(1, 0, 32'h10, 32'hDEAD_BEEF);
    n_chk++; if (s_ram_we0 !== 1'b1) begin n_err++; $display("FAIL w0_store_we: got %b want 1", s_ram_we0); end
    n_chk++; if (s_ram_addr0 !== 10'd4) begin n_err++; $display("FAIL w0_store_addr: got %0d want 4", s_ram_addr0); end
    n_chk++; if (s_stall0 !== 1'b0) begin n_err++; $display("FAIL w0_store_stall: got %b want 0", s_stall0); end
    bus_cycle(0, 0, 0, 0);
    n_chk++; if (s_ram_we0 !== 1'b0) begin n_err++; $display("FAIL w0_we_one_cycle: got %b want 0", s_ram_we0); end
    bus_cycle(0, 1, 32'h10, 0);
    n_chk++; if (s_rdata0 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL w0_load_data: got %h want deadbeef", s_rdata0); end
    n_chk++; if (s_stall0 !== 1'b0) begin n_err++; $display("FAIL w0_load_stall: got %b want 0", s_stall0); end
  endtask

  // Store, store, load, load back to back on the 3-wait-state instance.
  task automatic test_ram_wait3();
    logic        a_we [4];
    logic [31:0] a_ad [4];
    logic [31:0] a_wd [4];
    logic [31:0] v0, v1, got;
    int          cyc, we_cnt, we_at;
    logic        done;
    logic [9:0]  done_addr;
    v0 = $urandom; v1 = $urandom;
    a_we = '{1'b1, 1'b1, 1'b0, 1'b0};
    a_ad = '{32'h20, 32'h24, 32'h20, 32'h24};
    a_wd = '{v0, v1, 32'd0, 32'd0};
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      cyc = 0; we_cnt = 0; we_at = -1; done = 1'b0; got = 0; done_addr = 0;
      while (!done && cyc < 8) begin
        bus_cycle(a_we[i], !a_we[i], a_ad[i], a_wd[i]);
        if (s_ram_we3) begin we_cnt++; we_at = cyc; end
        if (!s_stall3) begin done = 1'b1; got = s_rdata3; done_addr = s_ram_addr3; end
        else cyc++;
      end
      n_chk++; if (!done || cyc != 3) begin n_err++; $display("FAIL w3_stall_count[%0d]: got %0d done=%b want 3", i, cyc, done); end
      n_chk++; if (done_addr !== a_ad[i][11:2]) begin n_err++; $display("FAIL w3_addr[%0d]: got %0d want %0d", i, done_addr, a_ad[i][11:2]); end
      if (a_we[i]) begin
        n_chk++; if (we_cnt != 1 || we_at != 3) begin n_err++; $display("FAIL w3_store_we[%0d]: got %0d pulses at %0d want 1 at 3", i, we_cnt, we_at); end
      end else begin
        n_chk++; if (got !== ((i == 2) ? v0 : v1)) begin n_err++; $display("FAIL w3_load_data[%0d]: got %h want %h", i, got, (i == 2) ? v0 : v1); end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] v;
    v = $urandom;
    bus_cycle(1, 0, 32'h30, 32'h1111_2222);
    n_chk++; if (s_stall3 !== 1'b1 || s_ram_we3 !== 1'b0) begin n_err++; $display("FAIL rw_first_stall: got stall=%b we=%b want 1 0", s_stall3, s_ram_we3); end
    rst = 1'b1;
    bus_cycle(1, 0, 32'h30, 32'h1111_2222);
    rst = 1'b0;
    n_chk++; if (s_ram_we3 !== 1'b0) begin n_err++; $display("FAIL rw_rst_we: got %b want 0", s_ram_we3); end
    bus_cycle(1, 0, MB, v);
    n_chk++; if (s_stall3 !== 1'b0 || s_ram_we3 !== 1'b0) begin n_err++; $display("FAIL rw_after_rst: got stall=%b we=%b want 0 0", s_stall3, s_ram_we3); end
    n_chk++; if (mem3[12] !== 32'd0) begin n_err++; $display("FAIL rw_aborted_store: got %h want 0", mem3[12]); end
    bus_cycle(0, 1, MB, 0);
    n_chk++; if (s_rdata3 !== v || s_stall3 !== 1'b0) begin n_err++; $display("FAIL rw_mmio_readback: got %h stall=%b want %h 0", s_rdata3, s_stall3, v); end
    n_chk++; if (s_rdata0 !== e_rdata) begin n_err++; $display("FAIL rw_mmio_readback0: got %h want %h", s_rdata0, e_rdata); end
  endtask

  task automatic test_gpio();
    reset_pulse();
    bus_cycle(1, 0, MB + 32'h04, 32'h1234);
    bus_cycle(0, 1, MB + 32'h04, 0);
    n_chk++; if (s_gpio0[63:32] !== 32'h1234 || s_gpio0[31:0] !== 32'd0) begin n_err++; $display("FAIL gpio_out: got %h want 00001234_00000000", s_gpio0); end
    n_chk++; if (s_gpio0 !== e_gpio) begin n_err++; $display("FAIL gpio_model: got %h want %h", s_gpio0, e_gpio); end
    n_chk++; if (s_rdata0 !== 32'h1234) begin n_err++; $display("FAIL gpio_readback: got %h want 1234", s_rdata0); end
    bus_cycle(0, 1, MB + 32'h08, 0);
    n_chk++; if (s_rdata0 !== 32'd0) begin n_err++; $display("FAIL gpio_hole: got %h want 0", s_rdata0); end
  endtask

  task automatic test_timer();
    int rise, guard;
    logic bad;
    reset_pulse();
    bus_cycle(1, 0, MB + 32'h48, 32'd10);
    bus_cycle(1, 0, MB + 32'h4C, 32'd1);
    bus_cycle(1, 0, MB + 32'h44, 32'h5555);
    rise = -1; bad = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      bus_cycle(0, 0, 0, 0);
      if (s_irq0 !== e_irq) bad = 1'b1;
      if (s_irq0 === 1'b1 && rise < 0) rise = i;
    end
    n_chk++; if (bad) begin n_err++; $display("FAIL irq_trace: irq differed from model (last got %b want %b)", s_irq0, e_irq); end
    n_chk++; if (rise < 11 || rise > 12) begin n_err++; $display("FAIL irq_rise: got cycle %0d want 11..12", rise); end
    bus_cycle(1, 0, MB + 32'h4C, 32'd3);
    bus_cycle(0, 0, 0, 0);
    n_chk++; if (s_irq0 !== 1'b0) begin n_err++; $display("FAIL irq_w1c: got %b want 0", s_irq0); end
    // Pending latches with enable clear, irq stays low.
    bus_cycle(1, 0, MB + 32'h4C, 32'd0);
    bus_cycle(1, 0, MB + 32'h44, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 14; i++) begin
      bus_cycle(0, 0, 0, 0);
      if (s_irq0 !== 1'b0) bad = 1'b1;
    end
    n_chk++; if (bad) begin n_err++; $display("FAIL irq_disabled: got 1 want 0"); end
    bus_cycle(0, 1, MB + 32'h4C, 0);
    n_chk++; if (s_rdata0 !== 32'd2) begin n_err++; $display("FAIL pend_disabled: got %h want 2", s_rdata0); end
    // W1C in the same cycle as a match: set wins.
    bus_cycle(1, 0, MB + 32'h4C, 32'd2);
    bus_cycle(1, 0, MB + 32'h44, 32'd0);
    guard = 0;
    while (m_cnt != m_cmp && guard < 30) begin bus_cycle(0, 0, 0, 0); guard++; end
    bus_cycle(1, 0, MB + 32'h4C, 32'd3);
    bus_cycle(0, 1, MB + 32'h4C, 0);
    n_chk++; if (s_rdata0 !== 32'd3 || guard >= 30) begin n_err++; $display("FAIL w1c_vs_match: got %h want 3", s_rdata0); end
    n_chk++; if (s_irq0 !== 1'b1) begin n_err++; $display("FAIL w1c_vs_match_irq: got %b want 1", s_irq0); end
    // Counter write in the match cycle: counter clears, pending still sets.
    bus_cycle(1, 0, MB + 32'h4C, 32'd3);
    bus_cycle(1, 0, MB + 32'h44, 32'd0);
    guard = 0;
    while (m_cnt != m_cmp && guard < 30) begin bus_cycle(0, 0, 0, 0); guard++; end
    bus_cycle(1, 0, MB + 32'h44, 32'd0);
    bus_cycle(0, 1, MB + 32'h4C, 0);
    n_chk++; if (s_rdata0 !== 32'd3 || guard >= 30) begin n_err++; $display("FAIL clr_vs_match_pend: got %h want 3", s_rdata0); end
    bus_cycle(0, 1, MB + 32'h44, 0);
    n_chk++; if (s_rdata0 !== 32'd1) begin n_err++; $display("FAIL clr_vs_match_cnt: got %h want 1", s_rdata0); end
  endtask

  task automatic test_gpio_in();
    int first;
    logic bad;
    gpio_in = 32'd0;
    bus_cycle(0, 1, MB + 32'h40, 0);
    bus_cycle(0, 1, MB + 32'h40, 0);
    gpio_in = 32'hA5A5_0001;
    first = -1; bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_cycle(0, 1, MB + 32'h40, 0);
      if (s_rdata0 !== e_rdata) bad = 1'b1;
      if (s_rdata0 === 32'hA5A5_0001 && first < 0) first = i;
    end
    n_chk++; if (bad) begin n_err++; $display("FAIL gpio_in_model: last got %h want %h", s_rdata0, e_rdata); end
    n_chk++; if (first != 2) begin n_err++; $display("FAIL gpio_in_latency: got %0d want 2", first); end
    bus_cycle(0, 1, 32'h8000_0000, 0);
    n_chk++; if (s_rdata0 !== 32'd0 || s_stall0 !== 1'b0) begin n_err++; $display("FAIL unmapped0: got %h stall=%b want 0 0", s_rdata0, s_stall0); end
    n_chk++; if (s_rdata3 !== 32'd0 || s_stall3 !== 1'b0) begin n_err++; $display("FAIL unmapped3: got %h stall=%b want 0 0", s_rdata3, s_stall3); end
  endtask

  task automatic test_random();
    logic [7:0]  offs [8];
    logic [31:0] a, wd, exp_rd;
    logic        we, re;
    int          errs_before;
    offs = '{8'h00, 8'h04, 8'h08, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h50};
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0:       a = MB | {24'd0, offs[$urandom_range(0, 7)]};
        1:       a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        default: a = 32'h8000_0000 | {20'd0, 10'($urandom), 2'b00};
      endcase
      we = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 1) == 1);
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) gpio_in = $urandom;
      exp_q.push_back(model_read(a, re, we));
      bus_cycle(we, re, a, wd);
      exp_rd = exp_q.pop_front();
      errs_before = n_err;
      n_chk++; if (s_rdata0 !== exp_rd) begin n_err++; $display("FAIL rnd_rdata[%0d] a=%h: got %h want %h", i, a, s_rdata0, exp_rd); end
      n_chk++; if (s_stall0 !== 1'b0) begin n_err++; $display("FAIL rnd_stall[%0d]: got %b want 0", i, s_stall0); end
      n_chk++; if (s_irq0 !== e_irq) begin n_err++; $display("FAIL rnd_irq[%0d]: got %b want %b", i, s_irq0, e_irq); end
      n_chk++; if (s_gpio0 !== e_gpio) begin n_err++; $display("FAIL rnd_gpio[%0d]: got %h want %h", i, s_gpio0, e_gpio); end
      n_chk++; if (s_ram_we0 !== (we && a < 32'h1000)) begin n_err++; $display("FAIL rnd_ram_we[%0d] a=%h: got %b want %b", i, a, s_ram_we0, we && a < 32'h1000); end
      if (n_err - errs_before > 0 && n_err > 20) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 32'd0; mem3[i] = 32'd0; m_ram[i] = 32'd0;
    end
    model_reset();
    rst = 1'b1; cpu_we = 0; cpu_re = 0; cpu_addr = 0; cpu_wdata = 0; gpio_in = 0;
    @(posedge clk); #1;
    test_reset();
    test_ram_wait0();
    test_ram_wait3();
    test_reset_in_wait();
    test_gpio();
    test_timer();
    test_gpio_in();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/soc_mem_bus.md
# soc_mem_bus

Parametrised data-side memory bus for the pipelined-CPU test SoC. It sits between the CPU data port (`Addr_out`/`Data_out`/`MemRW`/`Data_in`) and the data RAM. It decodes each access to either RAM, with a configurable number of wait states and a CPU stall handshake, or to a memory-mapped peripheral page. The peripheral page holds N GPIO output registers, a synchronised input port, a free-running cycle counter and a compare timer with an interrupt. Instruction ROM stays directly attached to the CPU and is outside this block.

## Interface
Parameters:
- `RAM_AW`, 10, RAM word-address width; RAM spans byte addresses 0 .. 4·2^RAM_AW−1.
- `RAM_WAIT`, 0, stall cycles per RAM access; legal 0..7.
- `N_OUT`, 2, number of 32-bit GPIO output registers; legal 1..16.
- `MMIO_BASE`, 32'hF000_0000, base of the 256-byte peripheral page; bits [7:0] must be 0.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cpu_addr`  in  32  byte address from the CPU MEM stage.
- `cpu_wdata`  in  32  store data.
- `cpu_we`  in  1  store request.
- `cpu_re`  in  1  load request.
- `cpu_rdata`  out  32  load data to the CPU.
- `cpu_stall`  out  1  hold the MEM stage and everything behind it.
- `ram_addr`  out  RAM_AW  RAM word address, equal to `cpu_addr[RAM_AW+1:2]`.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  32  equal to `cpu_wdata`.
- `ram_rdata`  in  32  RAM read data, valid before the next rising edge (RAM clocked on ~clk).
- `gpio_out`  out  32·N_OUT  output register k occupies bits [32k+31:32k].
- `gpio_in`  in  32  asynchronous input port.
- `irq`  out  1  timer interrupt, level.

## Operation
- Request condition: `cpu_we | cpu_re`. If both are high, the access is treated as a write.
- Address decode:
  - `cpu_addr[31:8] == MMIO_BASE[31:8]` selects MMIO.
  - `cpu_addr < 4·2^RAM_AW` selects RAM.
  - Any other address is unmapped: reads return 0, writes are ignored, and the access never stalls.
- RAM FSM states are IDLE and WAIT, with a 3-bit counter `cnt`.
  - RAM_WAIT=0: the FSM stays in IDLE. An access completes in its own cycle with `cpu_stall`=0, `ram_we`=`cpu_we`, and `cpu_rdata`=`ram_rdata`.
  - RAM_WAIT=W>0, in IDLE with a RAM request: `cpu_stall`=1, `ram_we`=0, `cnt`←W−1, go to WAIT.
  - In WAIT with `cnt`≠0: `cpu_stall`=1, `cnt` decrements.
  - In WAIT with `cnt`=0 (completion cycle): `cpu_stall`=0, `ram_we`=`cpu_we`, `cpu_rdata`=`ram_rdata`, go to IDLE.
  - `ram_we` is high for at most one cycle per store.
- MMIO is always zero-wait. Reads are combinational from the registers. Writes take effect at the edge. Offsets:
  - 0x00+4k: `gpio_out[k]`, R/W, for k<N_OUT.
  - 0x40: `gpio_in` after a 2-flop synchroniser, RO.
  - 0x44: cycle counter, +1 every cycle, wraps at 2^32. A write of any value clears it to 0.
  - 0x48: compare, R/W.
  - 0x4C: control/status. Bit0 = enable (R/W). Bit1 = pending: set when counter == compare; writing 1 clears it, writing 0 has no effect. Other bits read 0.
  - All other offsets read 0; writes to them are ignored.
- `irq` = pending & enable. Pending latches regardless of enable.
- `cpu_rdata` = 0 whenever there is no read or the access is unmapped.

## Timing
- Reset values: `cpu_stall`=0, `ram_we`=0, `irq`=0, every `gpio_out` register=0, counter=0, compare=32'hFFFF_FFFF, control=0, synchroniser=0, FSM=IDLE, `cnt`=0.
- A RAM access costs exactly RAM_WAIT stall cycles. Back-to-back RAM accesses each pay the full penalty.
- MMIO and unmapped accesses never assert `cpu_stall`, including when RAM_WAIT>0.
- `gpio_in` is readable 2 cycles after it changes.
- Compare match is evaluated on the pre-edge counter value; pending is set at that edge.
- Simultaneous events:
  - Counter write and match in the same cycle: the counter clears and pending still sets.
  - W1C on pending and a new match in the same cycle: set wins.
- Reset during WAIT: next cycle FSM=IDLE, `cpu_stall`=0, and no `ram_we` is issued for the aborted store.
- `irq` is registered-path only: it changes one edge after the match or control write.

## Test plan
- RAM_WAIT=0: store 32'hDEAD_BEEF to 0x10, then load from 0x10. Required: `ram_we` high for 1 cycle, `ram_addr`=4, `cpu_stall` never high, `cpu_rdata`=32'hDEAD_BEEF.
- RAM_WAIT=3: load from 0x20. Required: `cpu_stall` high for exactly 3 cycles, then data on the 4th cycle. A store must show `ram_we` only in the 4th cycle.
- RAM_WAIT=3, assert `rst` in the 2nd stall cycle of a store. Required: `cpu_stall`=0 the next cycle and `ram_we` never high. A following MMIO write to 0x00 completes with no stall.
- N_OUT=2: write 32'h1234 to MMIO_BASE+0x04 and read it back. Required: `gpio_out[63:32]`=32'h1234 and `gpio_out[31:0]`=0. A read of MMIO_BASE+0x08 returns 0.
- Write compare=10, control=1, counter=0. Required: `irq` rises 11–12 cycles later. W1C of pending drops `irq`. With enable=0, pending still sets and `irq` stays 0.
- Drive `gpio_in`=32'hA5A5_0001. Required: a read of +0x40 returns the new value no earlier than 2 cycles after the change. A load from 0x8000_0000 returns 0 with no stall.
